// File: rtl/serial_cmd_rx.sv
// Serial command receiver: 11-bit frames assembled into operand packets, checked
// with a serial CRC-4, and presented through a single-entry valid/ready register.
module serial_cmd_rx #(
  parameter int unsigned OPW  = 32,
  parameter int unsigned NOPS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sin,
  output logic [NOPS*OPW-1:0] cmd_data,
  output logic [2:0]          cmd_op,
  output logic [2:0]          cmd_err,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                frame_err,
  output logic                overrun
);

  localparam int unsigned DW = NOPS * OPW;
  localparam int unsigned NB = DW / 8;
  localparam int unsigned CW = $clog2(NB + 2);
  localparam logic [CW-1:0] ByteCntFull = CW'(NB);
  localparam logic [CW-1:0] ByteCntSat  = CW'(NB + 1);

  typedef enum logic [1:0] {StIdle, StType, StPayload, StStop} state_e;

  state_e state_q, state_d;

  logic          sin_s1_q, sin_s2_q, sin_s;
  logic          type_q, type_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    crc_work_q, crc_work_d;
  logic [3:0]    crc_q, crc_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;
  logic [2:0]    cmd_op_q, cmd_op_d;
  logic [2:0]    cmd_err_q, cmd_err_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic capture_type, shift_bit, stop_ok, stop_bad;
  logic data_done, ctl_done;
  logic crc_feed, crc_bit;
  logic op_legal, err_data, err_crc, err_op;

  // x^4 + x + 1, MSB-first, one message bit per call.
  function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  // Idle-high reset value keeps the synchroniser from faking a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_s1_q <= 1'b1;
      sin_s2_q <= 1'b1;
    end else begin
      sin_s1_q <= sin;
      sin_s2_q <= sin_s1_q;
    end
  end

  assign sin_s = sin_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!sin_s) state_d = StType;
      StType:    state_d = StPayload;
      StPayload: if (bit_cnt_q == 3'd7) state_d = StStop;
      StStop:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    capture_type = 1'b0;
    shift_bit    = 1'b0;
    stop_ok      = 1'b0;
    stop_bad     = 1'b0;
    unique case (state_q)
      StType:    capture_type = 1'b1;
      StPayload: shift_bit = 1'b1;
      StStop: begin
        stop_ok  = sin_s;
        stop_bad = !sin_s;
      end
      default: ;
    endcase
  end

  assign data_done = stop_ok && !type_q;
  assign ctl_done  = stop_ok && type_q;

  // Ctl payload bit 7 is replaced by a constant 1 in the CRC stream; the low
  // four ctl bits are the received CRC and are not fed.
  assign crc_feed = shift_bit && (!type_q || !bit_cnt_q[2]);
  assign crc_bit  = (type_q && bit_cnt_q == 3'd0) ? 1'b1 : sin_s;

  always_comb begin
    op_legal = 1'b0;
    case (shift_q[6:4])
      3'b000, 3'b001, 3'b100, 3'b101: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
  end

  assign err_data = byte_cnt_q != ByteCntFull;
  assign err_crc  = !err_data && (crc_work_q != shift_q[3:0]);
  assign err_op   = !err_data && !err_crc && (shift_q[7] || !op_legal);

  always_comb begin
    type_d      = type_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    crc_work_d  = crc_work_q;
    crc_d       = crc_q;
    byte_cnt_d  = byte_cnt_q;
    opnd_d      = opnd_q;
    cmd_data_d  = cmd_data_q;
    cmd_op_d    = cmd_op_q;
    cmd_err_d   = cmd_err_q;
    cmd_valid_d = cmd_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (capture_type) begin
      type_d     = sin_s;
      bit_cnt_d  = 3'd0;
      crc_work_d = crc_q;
    end

    if (shift_bit) begin
      shift_d   = {shift_q[6:0], sin_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (crc_feed) crc_work_d = crc4_step(crc_work_q, crc_bit);
    end

    if (stop_bad) frame_err_d = 1'b1;

    if (data_done) begin
      opnd_d = (opnd_q << 8) | DW'(shift_q);
      crc_d  = crc_work_q;
      if (byte_cnt_q != ByteCntSat) byte_cnt_d = byte_cnt_q + CW'(1);
    end

    if (ctl_done) begin
      opnd_d     = '0;
      crc_d      = 4'h0;
      byte_cnt_d = '0;
    end

    // A completed packet may replace the held one only if it is being taken now.
    if (ctl_done && (!cmd_valid_q || cmd_ready)) begin
      cmd_data_d  = opnd_q;
      cmd_op_d    = shift_q[6:4];
      cmd_err_d   = {err_data, err_crc, err_op};
      cmd_valid_d = 1'b1;
    end else begin
      if (ctl_done) overrun_d = 1'b1;
      if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      crc_work_q  <= 4'h0;
      crc_q       <= 4'h0;
      byte_cnt_q  <= '0;
      opnd_q      <= '0;
      cmd_data_q  <= '0;
      cmd_op_q    <= 3'b000;
      cmd_err_q   <= 3'b000;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      type_q      <= type_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      crc_work_q  <= crc_work_d;
      crc_q       <= crc_d;
      byte_cnt_q  <= byte_cnt_d;
      opnd_q      <= opnd_d;
      cmd_data_q  <= cmd_data_d;
      cmd_op_q    <= cmd_op_d;
      cmd_err_q   <= cmd_err_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_data  = cmd_data_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_err   = cmd_err_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx: hand-computed packets, CRCs and handshake timing.
module tb_serial_cmd_rx;

  localparam int unsigned OPW  = 32;
  localparam int unsigned NOPS = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sin;
  logic                cmd_ready;
  logic [NOPS*OPW-1:0] cmd_data;
  logic [2:0]          cmd_op;
  logic [2:0]          cmd_err;
  logic                cmd_valid;
  logic                frame_err;
  logic                overrun;

  int tests_run    = 0;
  int tests_failed = 0;
  int fe_cnt       = 0;
  int ov_cnt       = 0;

  serial_cmd_rx #(
    .OPW (OPW),
    .NOPS(NOPS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sin      (sin),
    .cmd_data (cmd_data),
    .cmd_op   (cmd_op),
    .cmd_err  (cmd_err),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters: each cycle high counts once, so a one-cycle pulse adds 1.
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_zeros(input int n);
    repeat (n) send_frame(1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_seq();
    for (int i = 1; i <= 8; i++) send_frame(1'b0, 8'(i), 1'b1);
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sin = 1'b1;
    cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (cmd_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid=%b fe=%b ov=%b want 0 0 0",
               cmd_valid, frame_err, overrun);
    end
    tests_run++;
    if (cmd_data !== 64'h0 || cmd_op !== 3'b000 || cmd_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_regs: got data=%h op=%b err=%b want 0 000 000",
               cmd_data, cmd_op, cmd_err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_packet();
    send_zeros(8);
    send_frame(1'b1, 8'h0B, 1'b1);
    send_bit(1'b1);
    tests_run++;
    if (cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_early: got %b want 0 one cycle after stop edge", cmd_valid);
    end
    send_bit(1'b1);
    tests_run++;
    if (cmd_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL valid_rise: got %b want 1", cmd_valid);
    end
    tests_run++;
    if (cmd_data !== 64'h0 || cmd_op !== 3'b000 || cmd_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL zero_pkt: got data=%h op=%b err=%b want 0 000 000",
               cmd_data, cmd_op, cmd_err);
    end
    accept();
    tests_run++;
    if (cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_fall: got %b want 0", cmd_valid);
    end
  endtask

  task automatic test_crc_err();
    send_zeros(8);
    send_frame(1'b1, 8'h0C, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_err !== 3'b010) begin
      tests_failed++;
      $display("FAIL crc_err: got valid=%b err=%b want 1 010", cmd_valid, cmd_err);
    end
    accept();
  endtask

  task automatic test_data_err();
    send_zeros(7);
    send_frame(1'b1, 8'h40, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_err !== 3'b100) begin
      tests_failed++;
      $display("FAIL data_err: got valid=%b err=%b want 1 100", cmd_valid, cmd_err);
    end
    accept();
    send_zeros(8);
    send_frame(1'b1, 8'h0B, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL after_data_err: got valid=%b err=%b want 1 000", cmd_valid, cmd_err);
    end
    accept();
  endtask

  task automatic test_operands();
    send_seq();
    send_frame(1'b1, 8'h1E, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_data !== 64'h0102030405060708) begin
      tests_failed++;
      $display("FAIL operands_data: got %h want 0102030405060708", cmd_data);
    end
    tests_run++;
    if (cmd_op !== 3'b001 || cmd_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL operands_op: got op=%b err=%b want 001 000", cmd_op, cmd_err);
    end
    accept();
  endtask

  task automatic test_op_err();
    send_zeros(8);
    send_frame(1'b1, 8'h2D, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_op !== 3'b010 || cmd_err !== 3'b001) begin
      tests_failed++;
      $display("FAIL op_illegal: got op=%b err=%b want 010 001", cmd_op, cmd_err);
    end
    accept();
    send_zeros(8);
    send_frame(1'b1, 8'h8B, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_op !== 3'b000 || cmd_err !== 3'b001) begin
      tests_failed++;
      $display("FAIL op_bit7: got op=%b err=%b want 000 001", cmd_op, cmd_err);
    end
    accept();
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    send_zeros(8);
    send_frame(1'b1, 8'h0B, 1'b1);
    idle(3);
    send_seq();
    send_frame(1'b1, 8'h1E, 1'b1);
    idle(3);
    tests_run++;
    if (ov_cnt - ov0 !== 1) begin
      tests_failed++;
      $display("FAIL overrun_pulse: got %0d cycles want 1", ov_cnt - ov0);
    end
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_data !== 64'h0 || cmd_op !== 3'b000) begin
      tests_failed++;
      $display("FAIL overrun_hold: got valid=%b data=%h op=%b want 1 0 000",
               cmd_valid, cmd_data, cmd_op);
    end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    send_seq();
    send_frame(1'b1, 8'h1E, 1'b1);
    send_bit(1'b1);
    cmd_ready = 1'b1;
    send_bit(1'b1);
    cmd_ready = 1'b0;
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_data !== 64'h0102030405060708 || cmd_op !== 3'b001) begin
      tests_failed++;
      $display("FAIL b2b_load: got valid=%b data=%h op=%b want 1 0102030405060708 001",
               cmd_valid, cmd_data, cmd_op);
    end
    idle(2);
    tests_run++;
    if (ov_cnt != ov0) begin
      tests_failed++;
      $display("FAIL b2b_overrun: got %0d pulses want 0", ov_cnt - ov0);
    end
    accept();
    tests_run++;
    if (cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_fall: got %b want 0", cmd_valid);
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_zeros(2);
    send_frame(1'b0, 8'h00, 1'b0);
    send_zeros(5);
    send_frame(1'b1, 8'h0B, 1'b1);
    idle(3);
    tests_run++;
    if (fe_cnt - fe0 !== 1) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: got %0d cycles want 1", fe_cnt - fe0);
    end
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_err !== 3'b100) begin
      tests_failed++;
      $display("FAIL frame_err_count: got valid=%b err=%b want 1 100", cmd_valid, cmd_err);
    end
  endtask

  task automatic test_mid_reset();
    send_zeros(3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cmd_valid !== 1'b0 || cmd_data !== 64'h0 || cmd_op !== 3'b000 ||
        cmd_err !== 3'b000 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got valid=%b data=%h op=%b err=%b fe=%b ov=%b want all 0",
               cmd_valid, cmd_data, cmd_op, cmd_err, frame_err, overrun);
    end
    sin = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    send_seq();
    send_frame(1'b1, 8'h1E, 1'b1);
    idle(3);
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_err !== 3'b000 || cmd_op !== 3'b001 ||
        cmd_data !== 64'h0102030405060708) begin
      tests_failed++;
      $display("FAIL post_reset_pkt: got valid=%b err=%b op=%b data=%h want 1 000 001 0102030405060708",
               cmd_valid, cmd_err, cmd_op, cmd_data);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_zero_packet();
    test_crc_err();
    test_data_err();
    test_operands();
    test_op_err();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_cmd_rx.md
SERIAL_CMD_RX -- requirements
Module: serial_cmd_rx

Interface
REQ-001 SHALL have parameter OPW, default 32: operand width in bits; must be a multiple of 8, minimum 8.
REQ-002 SHALL have parameter NOPS, default 2: number of operands per packet, 1..8.
REQ-003 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port sin  in  1: serial input, idle high.
REQ-006 SHALL have port cmd_data  out  NOPS*OPW: assembled operands; the first received byte lands in the MSB byte.
REQ-007 SHALL have port cmd_op  out  3: received opcode.
REQ-008 SHALL have port cmd_err  out  3: error flags {ERR_DATA, ERR_CRC, ERR_OP}.
REQ-009 SHALL have port cmd_valid  out  1: cmd_* outputs hold a completed packet.
REQ-010 SHALL have port cmd_ready  in  1: consumer accepts the packet.
REQ-011 SHALL have port frame_err  out  1: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun  out  1: one-cycle pulse when a completed packet is dropped.

Function
REQ-013 Frame SHALL be 11 bits, one bit per clock, MSB first: start 0, type bit (0 = data, 1 = ctl), 8 payload bits, stop 1.
REQ-014 The bit-level FSM SHALL have states IDLE, TYPE, PAYLOAD, STOP: IDLE->TYPE on sin==0; TYPE->PAYLOAD unconditionally; PAYLOAD->STOP after 8 bits; STOP->IDLE.
REQ-015 A stop bit of 0 SHALL pulse frame_err, discard that byte, and leave the packet state otherwise unchanged.
REQ-016 A data byte SHALL shift into the operand buffer and increment the byte counter, which saturates at NOPS*OPW/8+1.
REQ-017 A ctl byte SHALL terminate the packet; its payload is {1'b0, op[2:0], crc[3:0]}, and a payload bit 7 of 1 sets ERR_OP.
REQ-018 ERR_DATA SHALL be set when the byte count at the ctl byte is not exactly NOPS*OPW/8; on ERR_DATA, ERR_CRC and ERR_OP SHALL be 0.
REQ-019 The expected CRC SHALL be CRC-4: polynomial x^4+x+1, initial value 0, non-reflected, computed over {all operand bits in receive order, 1'b1, op[2:0]}, computed serially as bits arrive.
REQ-020 ERR_CRC SHALL be set on a mismatch; when ERR_CRC is set, ERR_OP SHALL be 0.
REQ-021 ERR_OP SHALL be set for an op outside {000 and, 001 or, 100 add, 101 sub}.
REQ-022 cmd_valid SHALL rise on the cycle after the ctl-byte stop bit is sampled; erroneous packets are also presented, with cmd_err nonzero.
REQ-023 cmd_data, cmd_op and cmd_err SHALL be stable while cmd_valid is high.
REQ-024 cmd_valid SHALL fall on the cycle after cmd_valid && cmd_ready.
REQ-025 A packet completing while cmd_valid && !cmd_ready SHALL be dropped and overrun pulsed; the held packet is kept.
REQ-026 A packet completing on the same cycle as an accepting handshake SHALL be loaded, and cmd_valid SHALL stay high.
REQ-027 After a ctl byte, both good and bad, the byte counter, CRC and operand buffer SHALL clear for the next packet.
REQ-028 sin SHALL be used through a 2-flop synchroniser, giving a fixed 2-cycle input latency that applies to all timing above.

Reset
REQ-029 While rst_n is low: FSM in IDLE; counter, CRC, cmd_data, cmd_op and cmd_err all 0; cmd_valid, frame_err and overrun all 0.
REQ-030 Reset asserted mid-frame or mid-packet SHALL discard all partial state; reception resumes at the next start bit after release.

Verification
REQ-031 Defaults; 8 data bytes 0x00, then ctl {0,000,1011} -> cmd_valid, cmd_data=0, cmd_op=000, cmd_err=000.
REQ-032 Same packet with crc 1100 -> cmd_valid, cmd_err=010.
REQ-033 7 data bytes, then ctl with op 100 -> cmd_err=100; a following correct packet -> cmd_err=000.
REQ-034 Defaults; bytes 0x01..0x08, op 001, correct CRC -> cmd_data=0x0102030405060708.
REQ-035 cmd_ready held 0 across two good packets -> first held, one overrun pulse; cmd_ready=1 -> first packet accepted, cmd_valid falls.
REQ-036 Stop bit forced to 0 on byte 3 -> frame_err pulse, 7 bytes counted, cmd_err=100; rst_n pulse mid-byte -> all outputs 0, next packet decodes cleanly.
